// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: MSB-first bits into WIDTH-bit words; word is registered on the edge sampling the last frame bit.
// One-entry valid/ready output register. A completion while full and not ready drops the new word and pulses overrun.
// Optional even-parity framing when SIPO_RX_PARITY_EN is defined (frame = WIDTH data bits + 1 parity bit).
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    input  logic                          serial_valid,
    input  logic                          sync,
    output logic [WIDTH-1:0]              parallel_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
    output logic                          parity_err,
    output logic [$clog2(WIDTH+2)-1:0]    bit_count
);

`ifdef SIPO_RX_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW  = $clog2(WIDTH + 2);
    // Only FL-1 earlier bits are ever needed to form the word, so the shifter is that wide.
    localparam int SHW = FL - 1;

    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] word;
    logic             complete;
    logic             load;

    assign complete = serial_valid && !sync && (bit_count == CW'(FL - 1));
    assign load     = complete && (!out_valid || out_ready);

`ifdef SIPO_RX_PARITY_EN
    logic par;
    assign word = sh;
    assign par  = ^{sh, serial_in};
`else
    assign word = {sh, serial_in};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh        <= '0;
            bit_count <= '0;
        end else if (serial_valid) begin
            if (sync) begin
                sh        <= SHW'(serial_in);
                bit_count <= CW'(1);
            end else begin
                sh        <= SHW'({sh, serial_in});
                bit_count <= complete ? '0 : bit_count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= complete && out_valid && !out_ready;
            if (load) begin
                parallel_out <= word;
                out_valid    <= 1'b1;
            end else if (out_ready) begin
                out_valid    <= 1'b0;
            end
        end
    end

`ifdef SIPO_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= par;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx (WIDTH=4); the parity sequence runs only when SIPO_RX_PARITY_EN is defined.
module tb_sipo_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b0;
    logic       serial_valid = 1'b0;
    logic       sync = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] parallel_out;
    logic       out_valid;
    logic       overrun;
    logic       parity_err;
    logic [2:0] bit_count;

    int n_cmp = 0;
    int n_err = 0;

    sipo_rx #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .sync         (sync),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .parity_err   (parity_err),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one qualified bit at the falling edge; return 1ns after the sampling edge.
    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        serial_in    = b;
        sync         = s;
        serial_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serial_valid = 1'b0;
            sync         = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pout"}, parallel_out, 0);
        check({tag, "_ov"},   out_valid,    0);
        check({tag, "_orun"}, overrun,      0);
        check({tag, "_perr"}, parity_err,   0);
        check({tag, "_bc"},   bit_count,    0);
    endtask

    initial begin
        #12;
        check_zero("rst");
        @(negedge clk);
        rst = 1'b1;

`ifdef SIPO_RX_PARITY_EN
        out_ready = 1'b1;
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        check("p1_bc4", bit_count, 4);
        check("p1_ov_early", out_valid, 0);
        send_bit(1, 0);
        check("p1_ov", out_valid, 1);
        check("p1_pout", parallel_out, 4'b1011);
        check("p1_perr", parity_err, 0);
        check("p1_bc", bit_count, 0);
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        send_bit(0, 0);
        check("p2_ov", out_valid, 1);
        check("p2_pout", parallel_out, 4'b1011);
        check("p2_perr", parity_err, 1);
        idle(1);
        check("p2_clear", out_valid, 0);
`else
        // Basic word, consumer stalled
        send_bit(1, 0); check("t1_bc1", bit_count, 1);
        send_bit(0, 0); check("t1_bc2", bit_count, 2);
        send_bit(1, 0); check("t1_bc3", bit_count, 3);
        check("t1_ov_early", out_valid, 0);
        send_bit(1, 0); check("t1_bc0", bit_count, 0);
        check("t1_ov", out_valid, 1);
        check("t1_pout", parallel_out, 4'b1011);
        out_ready = 1'b1;
        idle(1);
        check("t1_clear", out_valid, 0);
        check("t1_pout_hold", parallel_out, 4'b1011);

        // Back-to-back: accept coincides with next completion, no bubble
        out_ready = 1'b0;
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        check("t2_ov1", out_valid, 1);
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        check("t2_ov_mid", out_valid, 1);
        check("t2_pout_mid", parallel_out, 4'b1011);
        out_ready = 1'b1;
        send_bit(0, 0);
        check("t2_ov2", out_valid, 1);
        check("t2_pout2", parallel_out, 4'b1100);
        check("t2_orun", overrun, 0);
        idle(1);
        check("t2_clear", out_valid, 0);

        // Overrun
        out_ready = 1'b0;
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
        check("t3_orun_pre", overrun, 0);
        send_bit(0, 0);
        check("t3_orun", overrun, 1);
        check("t3_pout", parallel_out, 4'b1011);
        check("t3_ov", out_valid, 1);
        check("t3_bc", bit_count, 0);
        idle(1);
        check("t3_orun_pulse", overrun, 0);
        check("t3_ov_hold", out_valid, 1);
        out_ready = 1'b1;
        idle(1);
        check("t3_clear", out_valid, 0);

        // Sync discards a partial frame; gaps between bits
        out_ready = 1'b0;
        send_bit(1, 0); send_bit(1, 0);
        check("t4_bc2", bit_count, 2);
        send_bit(0, 1);
        check("t4_bc_sync", bit_count, 1);
        idle(3); send_bit(0, 0);
        idle(3); send_bit(1, 0);
        check("t4_no_word", out_valid, 0);
        idle(3); send_bit(1, 0);
        check("t4_ov", out_valid, 1);
        check("t4_pout", parallel_out, 4'b0011);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;

        // Reset mid-frame
        send_bit(1, 0); send_bit(0, 0);
        rst = 1'b0;
        #1;
        check_zero("t5_rst");
        @(posedge clk);
        #1;
        check_zero("t5_rst_hold");
        rst = 1'b1;
        send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
        check("t5_ov_early", out_valid, 0);
        send_bit(1, 0);
        check("t5_ov", out_valid, 1);
        check("t5_pout", parallel_out, 4'b0101);
        check("t5_perr", parity_err, 0);
`endif
        idle(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
